// File: rtl/mem_lut_bank.sv
// mem_lut_bank: banked, writable data-memory address lookup table.
// Combinational read, runtime write/increment and per-bank reload to defaults.
module mem_lut_bank #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int BANKS  = 4,
    parameter int BANK_W = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [BANK_W-1:0] BankSel,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Target,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              IncEn,
    input  logic [DATA_W-1:0] IncStep,
    input  logic              Reload,
    output logic              Busy,
    output logic              Done
);

    localparam int N   = 2 ** ADDR_W;
    localparam int NBA = 2 ** BANK_W;

    typedef enum logic [1:0] {
        IDLE,
        RELOAD,
        DONE_S
    } state_t;

    // Storage covers every encodable bank; banks at or above BANKS are never
    // written, so they stay at zero and their reads are forced to zero anyway.
    logic [DATA_W-1:0] mem [NBA][N];

    state_t            state;
    logic [ADDR_W:0]   cnt;
    logic [BANK_W-1:0] rbank;
    logic              busy_q;
    logic              done_q;
    logic              bank_ok;

    function automatic logic [DATA_W-1:0] dflt(input int b, input int i);
        logic [DATA_W-1:0] r;
        r = '0;
        if (b == 0) begin
            case (i)
                0: r = DATA_W'(180);
                1: r = DATA_W'(200);
                2: r = DATA_W'(30);
                3: r = DATA_W'(99);
                6: r = DATA_W'(62);
                7: r = DATA_W'(91);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    assign bank_ok = ({1'b0, BankSel} < (BANK_W + 1)'(BANKS));

    // Zero-latency read of the selected entry.
    assign Target = bank_ok ? mem[BankSel][Addr] : '0;
    assign Busy   = busy_q;
    assign Done   = done_q;

    // Storage updates and the reload sequencer share one block so the
    // increment-then-write ordering and the reload overwrite are explicit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NBA; b++) begin
                for (int i = 0; i < N; i++) begin
                    mem[b][i] <= dflt(b, i);
                end
            end
            state  <= IDLE;
            cnt    <= '0;
            rbank  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // Write is assigned after the increment so it wins on the same entry.
            if (!busy_q && bank_ok) begin
                if (IncEn) begin
                    mem[BankSel][Addr] <= mem[BankSel][Addr] + IncStep;
                end
                if (WrEn) begin
                    mem[BankSel][WrAddr] <= WrData;
                end
            end
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (Reload && bank_ok) begin
                        rbank  <= BankSel;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RELOAD;
                    end
                end
                RELOAD: begin
                    mem[rbank][cnt[ADDR_W-1:0]] <= dflt(int'(rbank), int'(cnt));
                    cnt <= cnt + 1'b1;
                    if (cnt == (ADDR_W + 1)'(N - 1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE_S;
                    end
                end
                DONE_S: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lut_bank.sv
// tb_mem_lut_bank: directed scenarios plus randomized traffic checked
// against an array-based reference model of the lookup table.
module tb_mem_lut_bank;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int NB = 3;
    localparam int BW = 2;
    localparam int N  = 8;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic [BW-1:0] BankSel;
    logic [AW-1:0] Addr;
    logic [DW-1:0] Target;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrData;
    logic          IncEn;
    logic [DW-1:0] IncStep;
    logic          Reload;
    logic          Busy;
    logic          Done;

    int total = 0;
    int bad   = 0;

    int model [NB][N];
    int rl_left;
    int rbank;
    bit in_done;

    mem_lut_bank #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .BANKS (NB),
        .BANK_W(BW)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .BankSel(BankSel),
        .Addr   (Addr),
        .Target (Target),
        .WrEn   (WrEn),
        .WrAddr (WrAddr),
        .WrData (WrData),
        .IncEn  (IncEn),
        .IncStep(IncStep),
        .Reload (Reload),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clk = ~Clk;

    function automatic int dflt(input int b, input int i);
        int t[8];
        t = '{180, 200, 30, 99, 0, 0, 62, 91};
        if (b == 0) return t[i];
        return 0;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < N; i++)
                model[b][i] = dflt(b, i);
        rl_left = 0;
        rbank   = 0;
        in_done = 0;
    endtask

    function automatic int exp_target();
        if (int'(BankSel) >= NB) return 0;
        return model[BankSel][Addr];
    endfunction

    // Apply one clock's worth of behaviour to the model using current inputs.
    task automatic model_step();
        bit was_done;
        int b;
        if (rl_left > 0) begin
            model[rbank][N - rl_left] = dflt(rbank, N - rl_left);
            rl_left--;
            in_done = (rl_left == 0);
        end else begin
            was_done = in_done;
            in_done  = 0;
            b = int'(BankSel);
            if (b < NB) begin
                if (IncEn)
                    model[b][Addr] = (model[b][Addr] + int'(IncStep)) % 256;
                if (WrEn)
                    model[b][WrAddr] = int'(WrData);
                if (Reload && !was_done) begin
                    rbank   = b;
                    rl_left = N;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic quiet();
        WrEn    = 1'b0;
        IncEn   = 1'b0;
        Reload  = 1'b0;
        WrAddr  = '0;
        WrData  = '0;
        IncStep = '0;
    endtask

    task automatic test_reset();
        int dv[8];
        dv = '{180, 200, 30, 99, 0, 0, 62, 91};
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags busy=%b done=%b want 0 0", Busy, Done);
        end
        BankSel = 2'd0;
        for (int i = 0; i < N; i++) begin
            Addr = AW'(i);
            #1;
            total++;
            if (Target !== DW'(dv[i])) begin
                bad++;
                $display("FAIL reset_bank0[%0d] got=%0d want=%0d", i, Target, dv[i]);
            end
        end
        BankSel = 2'd1;
        for (int i = 0; i < N; i += 3) begin
            Addr = AW'(i);
            #1;
            total++;
            if (Target !== 8'd0) begin
                bad++;
                $display("FAIL reset_bank1[%0d] got=%0d want=0", i, Target);
            end
        end
    endtask

    task automatic test_increment();
        int want[3];
        want = '{201, 202, 203};
        quiet();
        BankSel = 2'd0;
        Addr    = 3'd1;
        #1;
        total++;
        if (Target !== 8'd200) begin
            bad++;
            $display("FAIL inc_start got=%0d want=200", Target);
        end
        IncEn   = 1'b1;
        IncStep = 8'd1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if (Target !== DW'(want[k])) begin
                bad++;
                $display("FAIL inc_step%0d got=%0d want=%0d", k, Target, want[k]);
            end
        end
        IncStep = 8'hFF;
        cycle();
        total++;
        if (Target !== 8'd202) begin
            bad++;
            $display("FAIL inc_neg got=%0d want=202", Target);
        end
        IncEn  = 1'b0;
        WrEn   = 1'b1;
        WrAddr = 3'd1;
        WrData = 8'd255;
        cycle();
        WrEn    = 1'b0;
        IncEn   = 1'b1;
        IncStep = 8'd1;
        cycle();
        IncEn = 1'b0;
        total++;
        if (Target !== 8'd0) begin
            bad++;
            $display("FAIL inc_wrap got=%0d want=0", Target);
        end
    endtask

    task automatic test_collision();
        quiet();
        BankSel = 2'd0;
        Addr    = 3'd2;
        WrEn    = 1'b1;
        WrAddr  = 3'd2;
        WrData  = 8'd77;
        IncEn   = 1'b1;
        IncStep = 8'd5;
        cycle();
        quiet();
        total++;
        if (Target !== 8'd77) begin
            bad++;
            $display("FAIL collide_same got=%0d want=77", Target);
        end
        WrEn    = 1'b1;
        WrAddr  = 3'd3;
        WrData  = 8'd77;
        IncEn   = 1'b1;
        IncStep = 8'd5;
        cycle();
        quiet();
        total++;
        if (Target !== 8'd82) begin
            bad++;
            $display("FAIL collide_inc got=%0d want=82", Target);
        end
        Addr = 3'd3;
        #1;
        total++;
        if (Target !== 8'd77) begin
            bad++;
            $display("FAIL collide_wr got=%0d want=77", Target);
        end
    endtask

    task automatic test_reload();
        int busy_n;
        int done_n;
        quiet();
        BankSel = 2'd1;
        WrEn    = 1'b1;
        WrAddr  = 3'd4;
        WrData  = 8'd55;
        cycle();
        BankSel = 2'd0;
        for (int i = 0; i < N; i++) begin
            WrAddr = AW'(i);
            WrData = DW'(i + 1);
            cycle();
        end
        quiet();
        Reload = 1'b1;
        cycle();
        Reload = 1'b0;
        busy_n = (Busy === 1'b1) ? 1 : 0;
        done_n = 0;
        total++;
        if (Busy !== 1'b1) begin
            bad++;
            $display("FAIL reload_busy_rise got=%b want=1", Busy);
        end
        BankSel = 2'd1;
        WrEn    = 1'b1;
        WrAddr  = 3'd5;
        WrData  = 8'd9;
        for (int k = 0; k < 14; k++) begin
            cycle();
            WrEn = 1'b0;
            if (Busy === 1'b1) busy_n++;
            if (Done === 1'b1) done_n++;
        end
        total++;
        if (busy_n != N) begin
            bad++;
            $display("FAIL reload_busy_len got=%0d want=%0d", busy_n, N);
        end
        total++;
        if (done_n != 1) begin
            bad++;
            $display("FAIL reload_done_cnt got=%0d want=1", done_n);
        end
        BankSel = 2'd0;
        for (int i = 0; i < N; i++) begin
            Addr = AW'(i);
            #1;
            total++;
            if (Target !== DW'(dflt(0, i))) begin
                bad++;
                $display("FAIL reload_def[%0d] got=%0d want=%0d", i, Target, dflt(0, i));
            end
        end
        BankSel = 2'd1;
        Addr    = 3'd4;
        #1;
        total++;
        if (Target !== 8'd55) begin
            bad++;
            $display("FAIL reload_other got=%0d want=55", Target);
        end
        Addr = 3'd5;
        #1;
        total++;
        if (Target !== 8'd0) begin
            bad++;
            $display("FAIL reload_wr_drop got=%0d want=0", Target);
        end
    endtask

    task automatic test_reset_mid();
        int done_n;
        quiet();
        BankSel = 2'd2;
        WrEn    = 1'b1;
        WrAddr  = 3'd7;
        WrData  = 8'd33;
        cycle();
        BankSel = 2'd0;
        WrAddr  = 3'd0;
        WrData  = 8'd9;
        cycle();
        quiet();
        Reload = 1'b1;
        cycle();
        Reload = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        Reset_n = 1'b0;
        model_reset();
        BankSel = 2'd2;
        Addr    = 3'd7;
        #1;
        total++;
        if (Target !== 8'd0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async tgt=%0d busy=%b want 0 0", Target, Busy);
        end
        #3;
        Reset_n = 1'b1;
        done_n  = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (Done === 1'b1 || Busy === 1'b1) done_n++;
        end
        total++;
        if (done_n != 0) begin
            bad++;
            $display("FAIL midreset_nodone got=%0d want=0", done_n);
        end
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < N; i++) begin
                BankSel = BW'(b);
                Addr    = AW'(i);
                #1;
                total++;
                if (Target !== DW'(dflt(b, i))) begin
                    bad++;
                    $display("FAIL midreset_def[%0d][%0d] got=%0d want=%0d",
                             b, i, Target, dflt(b, i));
                end
            end
        end
    endtask

    task automatic test_bad_bank();
        quiet();
        BankSel = 2'd3;
        Addr    = 3'd2;
        WrEn    = 1'b1;
        WrAddr  = 3'd2;
        WrData  = 8'd123;
        Reload  = 1'b1;
        cycle();
        quiet();
        total++;
        if (Busy !== 1'b0 || Target !== 8'd0) begin
            bad++;
            $display("FAIL badbank busy=%b tgt=%0d want 0 0", Busy, Target);
        end
        cycle();
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL badbank_idle busy=%b done=%b want 0 0", Busy, Done);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            BankSel = BW'($urandom_range(0, 3));
            Addr    = AW'($urandom_range(0, N - 1));
            WrAddr  = AW'($urandom_range(0, N - 1));
            WrData  = DW'($urandom);
            IncStep = DW'($urandom);
            WrEn    = ($urandom_range(0, 3) == 0);
            IncEn   = ($urandom_range(0, 2) == 0);
            Reload  = ($urandom_range(0, 24) == 0);
            #1;
            total++;
            if (Target !== DW'(exp_target())) begin
                bad++;
                $display("FAIL rand_target k=%0d got=%0d want=%0d", k, Target, exp_target());
            end
            cycle();
            total++;
            if (Busy !== (rl_left > 0) || Done !== in_done) begin
                bad++;
                $display("FAIL rand_flags k=%0d busy=%b done=%b want %0d %0d",
                         k, Busy, Done, rl_left > 0, in_done);
            end
        end
        quiet();
    endtask

    initial begin
        Reset_n = 1'b0;
        BankSel = '0;
        Addr    = '0;
        quiet();
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        test_reset();
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        test_increment();
        test_collision();
        test_reload();
        test_reset_mid();
        test_bad_bank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_lut_bank.md
Name: mem_lut_bank

Overview:
- Parametrised, writable successor to the per-program memory-address lookup table.
- Holds BANKS independent tables of 2**ADDR_W data-memory addresses, one bank per program. Software selects a bank and reads targets combinationally.
- Adds runtime entry writes, signed post-increment of pointer/counter entries, and a sequential per-bank reload-to-defaults engine.
- Sits between the control decoder (Addr field) and the data-memory address mux.

Parameters:
- ADDR_W, 3, index width; entries per bank N = 2**ADDR_W.
- DATA_W, 8, entry width (data-memory address width).
- BANKS, 4, number of program banks.
- BANK_W, 2, bank-select width; must satisfy 2**BANK_W >= BANKS.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous reset, active-low.
- BankSel  in  BANK_W  active bank for read/write/increment.
- Addr  in  ADDR_W  read and increment index.
- Target  out  DATA_W  entry [BankSel][Addr], combinational.
- WrEn  in  1  write WrData into [BankSel][WrAddr].
- WrAddr  in  ADDR_W  write index.
- WrData  in  DATA_W  write value.
- IncEn  in  1  add IncStep to [BankSel][Addr].
- IncStep  in  DATA_W  two's-complement step.
- Reload  in  1  start restoring defaults of bank BankSel.
- Busy  out  1  reload in progress.
- Done  out  1  one-cycle pulse after the last reload write.

Behaviour:
- Defaults:
  - Bank 0 indices 0..7 = 180, 200, 30, 99, 0, 0, 62, 91.
  - Bank 0 indices >= 8 = 0.
  - All other banks = 0.
- Reset (Reset_n low, async):
  - Every entry of every bank takes its default.
  - FSM goes to IDLE, reload counter = 0.
  - Busy = 0, Done = 0.
  - Target reflects defaults immediately.
- Read:
  - Target = mem[BankSel][Addr], zero-cycle latency.
  - A write or increment becomes visible on the cycle after the edge; same-cycle read returns the old value.
  - BankSel >= BANKS reads 0. Writes, increments and reload to such a bank are ignored.
- Write: on the rising edge with WrEn=1 and Busy=0, mem[BankSel][WrAddr] <= WrData.
- Increment:
  - On the rising edge with IncEn=1 and Busy=0, mem[BankSel][Addr] <= mem + IncStep, modulo 2**DATA_W (wraps, no saturation, no flag).
  - Example: 255 + 1 = 0; 0 + 8'hFF = 255.
- Simultaneous write and increment:
  - Same entry (WrAddr == Addr): the write wins; the increment is dropped.
  - Different entries: both apply.
- FSM states:
  - IDLE: Reload=1 and a valid bank -> latch bank into RBank, counter = 0, go to RELOAD. Busy is high from the next cycle.
  - RELOAD: each cycle mem[RBank][counter] <= default, counter++. After writing index N-1, go to DONE.
  - DONE: Done=1 for one cycle, Busy=0, return to IDLE.
- Busy = 1 exactly in RELOAD, so it is high for N cycles.
- While Busy=1:
  - WrEn and IncEn are ignored (dropped, not queued).
  - Reload is ignored.
  - Target keeps reading live storage, so it may show partially restored contents.
  - BankSel may change freely; the reload stays on RBank.
- Reload and WrEn/IncEn asserted in the same IDLE cycle: the write/increment applies on that edge, then the reload later overwrites it.
- Reset asserted mid-reload: full default restore of all banks, IDLE, and no Done pulse.
- Counter width is ADDR_W+1, so the compare against N-1 does not wrap.

Test Plan:
- Release reset, BankSel=0, sweep Addr 0..7 -> Target = 180, 200, 30, 99, 0, 0, 62, 91. BankSel=1, any Addr -> 0.
- BankSel=0, Addr=1, IncEn=1, IncStep=1 for 3 cycles -> Target 200, 201, 202, 203. Then IncStep=8'hFF once -> 202. Entry set to 255 via write, then +1 -> 0.
- Same cycle WrEn=1, WrAddr=Addr=2, WrData=77, IncEn=1, IncStep=5 -> entry 77. Repeat with WrAddr=3 -> entry 3 = 77 and entry 2 = 82.
- Bank 0 entries 0..7 overwritten with 1..8, then Reload=1 -> Busy high for 8 cycles and Done pulses once. Bank 0 returns to defaults; bank 1 contents are unchanged. A WrEn during Busy has no effect.
- Reset_n pulsed low during reload cycle 4 (bank 0 and bank 2 both modified) -> all banks at defaults, Busy=0, and no Done pulse.
- BankSel=3 with BANKS=3: WrEn and Reload ignored, Target=0, Busy stays 0.
